// File: rtl/div16_seq.sv
// rtl/div16_seq.sv - sequential 16-bit unsigned restoring divider
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous active-low reset
//   start  in   1   operation request, sampled in IDLE only
//   a      in  16   dividend, captured on the accepted start edge
//   b      in  16   divisor, captured on the accepted start edge
//   q      out 16   quotient (held until the next accepted start)
//   r      out 16   remainder (held until the next accepted start)
//   dz     out  1   divide-by-zero flag of the last operation
//   busy   out  1   high while iterating
//   done   out  1   one-cycle pulse when q/r/dz become valid

module div16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] q,
    output logic [15:0] r,
    output logic        dz,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [15:0] w, w_nx;        // dividend shifting out, quotient shifting in
    logic [15:0] d, d_nx;        // divisor
    logic [15:0] p, p_nx;        // partial remainder
    logic [4:0]  cnt, cnt_nx;
    logic [15:0] q_nx, r_nx;
    logic        dz_nx, busy_nx, done_nx;

    // Trial subtract t - d done as t + ~{0,d} + 1; bit 17 is the carry-out,
    // which is 1 exactly when no borrow occurred (t >= d).
    logic [16:0] t;
    logic [17:0] sum;
    logic        co;
    logic [15:0] p_step, w_step;

    always_comb begin
        t      = {p, w[15]};
        sum    = {1'b0, t} + {1'b0, 1'b1, ~d} + 18'd1;
        co     = sum[17];
        p_step = co ? sum[15:0] : t[15:0];
        w_step = {w[14:0], co};
    end

    always_comb begin
        state_nx = state;
        w_nx     = w;
        d_nx     = d;
        p_nx     = p;
        cnt_nx   = cnt;
        q_nx     = q;
        r_nx     = r;
        dz_nx    = dz;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (b == 16'd0) begin
                        q_nx     = 16'hFFFF;
                        r_nx     = a;
                        dz_nx    = 1'b1;
                        done_nx  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        w_nx     = a;
                        d_nx     = b;
                        p_nx     = 16'd0;
                        cnt_nx   = 5'd0;
                        busy_nx  = 1'b1;
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                w_nx   = w_step;
                p_nx   = p_step;
                cnt_nx = cnt + 5'd1;
                if (cnt == 5'd15) begin
                    q_nx     = w_step;
                    r_nx     = p_step;
                    dz_nx    = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else begin
                    busy_nx = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            w     <= 16'd0;
            d     <= 16'd0;
            p     <= 16'd0;
            cnt   <= 5'd0;
            q     <= 16'd0;
            r     <= 16'd0;
            dz    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            w     <= w_nx;
            d     <= d_nx;
            p     <= p_nx;
            cnt   <= cnt_nx;
            q     <= q_nx;
            r     <= r_nx;
            dz    <= dz_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_div16_seq.sv
// tb/tb_div16_seq.sv - self-checking bench for div16_seq

module tb_div16_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    div16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .dz    (dz),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && busy && done) begin
            fails++;
            $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
        end
    end

    // One start pulse; checks latency, busy length, output stability and results.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [15:0] eq, input logic [15:0] er, input logic edz);
        int c;
        int bcnt;
        logic seen;
        logic moved;
        logic [15:0] q0, r0;
        @(negedge clk);
        q0 = q;
        r0 = r;
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        c = 0;
        bcnt = 0;
        seen = 1'b0;
        moved = 1'b0;
        while (c < 40 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) bcnt++;
                if (q !== q0 || r !== r0) moved = 1'b1;
                @(negedge clk);
                c++;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(c), edz ? 32'd0 : 32'd16);
        chk("busy_cycles", 32'(bcnt), edz ? 32'd0 : 32'd16);
        chk("outputs_stable", 32'(moved), 32'd0);
        chk("q", 32'(q), 32'(eq));
        chk("r", 32'(r), 32'(er));
        chk("dz", 32'(dz), 32'(edz));
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 32'd0);
    endtask

    vec_t vecs[16];

    initial begin
        int ndone;
        int last;
        int c;
        logic seen;
        logic [15:0] ra, rb;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = 16'd0;
        b = 16'd0;

        vecs[0]  = '{16'd150,   16'd50,    16'd3,     16'd0,     1'b0};
        vecs[1]  = '{16'd40000, 16'd7,     16'd5714,  16'd2,     1'b0};
        vecs[2]  = '{16'd65535, 16'd1,     16'd65535, 16'd0,     1'b0};
        vecs[3]  = '{16'd100,   16'd200,   16'd0,     16'd100,   1'b0};
        vecs[4]  = '{16'd5,     16'd0,     16'hFFFF,  16'd5,     1'b1};
        vecs[5]  = '{16'd9,     16'd3,     16'd3,     16'd0,     1'b0};
        vecs[6]  = '{16'd0,     16'd65535, 16'd0,     16'd0,     1'b0};
        vecs[7]  = '{16'd65535, 16'd65535, 16'd1,     16'd0,     1'b0};
        vecs[8]  = '{16'd12345, 16'd12345, 16'd1,     16'd0,     1'b0};
        vecs[9]  = '{16'd0,     16'd0,     16'hFFFF,  16'd0,     1'b1};
        vecs[10] = '{16'd65535, 16'd2,     16'd32767, 16'd1,     1'b0};
        vecs[11] = '{16'd1,     16'd65535, 16'd0,     16'd1,     1'b0};
        vecs[12] = '{16'd65534, 16'd65535, 16'd0,     16'd65534, 1'b0};
        vecs[13] = '{16'd65535, 16'd256,   16'd255,   16'd255,   1'b0};
        vecs[14] = '{16'd0,     16'd1,     16'd0,     16'd0,     1'b0};
        vecs[15] = '{16'd32768, 16'd3,     16'd10922, 16'd2,     1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_r", 32'(r), 32'd0);
        chk("reset_dz", 32'(dz), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].eq, vecs[i].er, vecs[i].edz);

        // start held high: one result every 18 cycles, a/b scrambled while busy
        @(negedge clk);
        a = 16'd1000;
        b = 16'd10;
        start = 1'b1;
        ndone = 0;
        last = -1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("held_q", 32'(q), 32'd100);
                chk("held_r", 32'(r), 32'd0);
                if (last >= 0) chk("held_interval", 32'(cyc - last), 32'd18);
                last = cyc;
            end
            if (busy) begin
                a = 16'($urandom);
                b = 16'($urandom);
            end else begin
                a = 16'd1000;
                b = 16'd10;
            end
        end
        start = 1'b0;
        chk("held_done_count", 32'(ndone), 32'd4);
        c = 0;
        seen = 1'b0;
        while (c < 40 && !seen) begin
            @(negedge clk);
            c++;
            if (done) seen = 1'b1;
        end
        chk("held_drain", 32'(seen), 32'd1);
        @(negedge clk);

        // reset during step 8 discards the operation
        @(negedge clk);
        a = 16'd40000;
        b = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrun_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_q", 32'(q), 32'd0);
        chk("midrst_r", 32'(r), 32'd0);
        chk("midrst_dz", 32'(dz), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("midrst_quiet", 32'(seen), 32'd0);
        run_op(16'd40000, 16'd7, 16'd5714, 16'd2, 1'b0);

        // random pairs against a behavioural reference
        for (int i = 0; i < 1500; i++) begin
            ra = 16'($urandom);
            rb = (i % 50 == 0) ? 16'd0 : ((i % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom));
            if (rb == 16'd0)
                run_op(ra, rb, 16'hFFFF, ra, 1'b1);
            else
                run_op(ra, rb, ra / rb, ra % rb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div16_seq.md
# div16_seq

Sequential 16-bit unsigned restoring divider: the inverse of the 16-bit adder datapath, producing quotient and remainder one bit per clock using a 17-bit subtract stage (add of inverted divisor with carry-in 1, carry-out = no borrow). It sits beside the adder in the ALU as the multi-cycle divide unit. A start/busy/done handshake sequences each operation. Quotient, remainder and divide-by-zero flag are held until the next accepted start.

## Interface
- No parameters; the width is fixed at 16.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- start  input  1  request; sampled only in IDLE.
- a  input  16  dividend, captured on the accepted start edge.
- b  input  16  divisor, captured on the accepted start edge.
- q  output  16  quotient, registered.
- r  output  16  remainder, registered.
- dz  output  1  divide-by-zero flag for the last operation, registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when q, r and dz become valid.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: 16 iterations.
  - DONE: one cycle, done=1.
- Reset (rst_n=0 at an edge):
  - state goes to IDLE.
  - q, r, dz, busy and done all go to 0.
  - The internal dividend/divisor registers and the 5-bit step counter go to 0.
  - Reset takes priority over everything, including mid-RUN; any in-flight operation is discarded and no done is produced.
- IDLE, start=1, b!=0:
  - Latch a into the working quotient register w and b into register d.
  - Clear the partial remainder p (16 bits) and the counter; go to RUN.
- IDLE, start=1, b==0:
  - Set q=16'hFFFF, r=a, dz=1; go directly to DONE.
- IDLE, start=0: hold state; q, r and dz keep their previous values.
- RUN step, one per clock:
  - t = {p, w[15]} (17 bits).
  - s = t + {1'b1, ~d} + 1 (17 bits plus carry-out co).
  - If co=1 (t >= d): p = s[15:0] and w = {w[14:0], 1'b1}.
  - Else: p = t[15:0] and w = {w[14:0], 1'b0}.
  - The counter increments; after the 16th step, q=w, r=p, dz=0, and the state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- start while busy (RUN) or in DONE: ignored, not queued. a and b may change freely after the accepting edge.
- Arithmetic: all values unsigned. The remainder always satisfies r < b when b != 0. No overflow is possible.

## Timing
- Start accepted at edge k (b != 0):
  - busy=1 after edge k, through the cycle ending at edge k+16.
  - q, r and dz update, done=1 and busy=0 after edge k+16.
  - done=0 and the state returns to IDLE after edge k+17.
- Earliest next accept is edge k+18, which gives a back-to-back throughput of 1 op per 18 cycles.
- Start accepted at edge k with b==0: done=1 after edge k; IDLE after edge k+1. busy never asserts.
- q, r and dz change only on the edge that enters DONE, or on reset. They are stable during and between operations.
- done and busy are never high simultaneously.
- No combinational path from any input to any output.

## Test plan
- Reset, then a=150, b=50, start pulse -> busy for 16 cycles; done pulse at k+16 with q=3, r=0, dz=0; done low at k+17.
- a=40000, b=7 -> q=5714, r=2. Then a=65535, b=1 -> q=65535, r=0. Then a=100, b=200 -> q=0, r=100.
- a=5, b=0 -> done one cycle after the start edge, q=16'hFFFF, r=5, dz=1, busy never high. The next op with a=9, b=3 clears dz (q=3, r=0).
- start held high continuously with a=1000, b=10 -> exactly one done every 18 cycles, q=100, r=0. Changing a and b mid-RUN does not alter the result.
- rst_n=0 for one edge at step 8 of a=40000, b=7 -> all outputs 0 next cycle, no done pulse; a fresh start afterwards yields q=5714, r=2.
- Exhaustive/random check against a reference model (q=a/b, r=a%b, including b=0 handling), e.g. 10,000 random pairs plus the corners a=0, b=65535, and a=b.
